// File: rtl/sort_pkg.sv
// Types and default sizes shared by the sort scheduler and the sort engine it drives.
package sort_pkg;

    localparam int SORT_N     = 6;
    localparam int SORT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or above ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (i + 32'(ptr)) % 32'(NREQ);
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sort_scheduler.sv
// Shares one sort engine between NREQ requesters: grant, issue, wait (with timeout), respond.
module sort_scheduler
    import sort_pkg::*;
#(
    parameter int N       = SORT_N,
    parameter int WIDTH   = SORT_WIDTH,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*N*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N*WIDTH-1:0]        rsp_data,
    output logic                      rsp_err,
    output logic                      eng_start,
    output logic [N*WIDTH-1:0]        eng_data,
    input  logic                      eng_done,
    input  logic [N*WIDTH-1:0]        eng_sorted,
    output logic                      busy,
    output logic [15:0]               jobs_done
);

    localparam int IDW = $clog2(NREQ);
    localparam int DW  = N * WIDTH;
    localparam int CW  = $clog2(TIMEOUT + 1);

    sched_state_t   state_q, state_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [DW-1:0]   payload;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  job_id_q;
    logic [DW-1:0]   eng_data_q;
    logic [DW-1:0]   rsp_data_q;
    logic            rsp_err_q;
    logic [CW-1:0]   wait_cnt_q;
    logic [15:0]     jobs_done_q;
    logic            timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        payload = '0;
        gnt_idx = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (gnt[j]) begin
                payload = req_data[j*DW +: DW];
                gnt_idx = IDW'(j);
            end
        end
    end

    assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (eng_done || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            job_id_q    <= '0;
            eng_data_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            jobs_done_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        eng_data_q <= payload;
                        job_id_q   <= gnt_idx;
                    end
                end
                ISSUE: wait_cnt_q <= '0;
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    // a completion in the timeout cycle still counts as success
                    if (eng_done) begin
                        rsp_data_q <= eng_sorted;
                        rsp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q    <= (job_id_q == IDW'(NREQ - 1)) ? '0 : job_id_q + 1'b1;
                        jobs_done_q <= jobs_done_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // grant is combinational, so hold it off while reset is asserted
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
    assign eng_start = (state_q == ISSUE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign eng_data  = eng_data_q;
    assign rsp_id    = job_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_sort_scheduler.sv
// Directed bench for sort_scheduler with a behavioural sort engine of configurable latency.
module tb_sort_scheduler;

    localparam int N       = 6;
    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int DW      = N * WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DW-1:0]    req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_err;
    logic                  eng_start;
    logic [DW-1:0]         eng_data;
    logic                  eng_done;
    logic [DW-1:0]         eng_sorted;
    logic                  busy;
    logic [15:0]           jobs_done;

    always #5 clk = ~clk;

    sort_scheduler #(
        .N       (N),
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_sorted (eng_sorted),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    function automatic logic [DW-1:0] pack6(input int e0, e1, e2, e3, e4, e5);
        return {8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [DW-1:0] sort6(input logic [DW-1:0] v);
        logic [WIDTH-1:0] a [N];
        logic [WIDTH-1:0] t;
        logic [DW-1:0]    r;
        for (int k = 0; k < N; k++) a[k] = v[k*WIDTH +: WIDTH];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        r = '0;
        for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = a[k];
        return r;
    endfunction

    // engine model: done pulses eng_lat cycles after the start cycle unless eng_never
    int            eng_lat   = 6;
    bit            eng_never = 1'b0;
    logic          eng_done_m;
    logic [DW-1:0] eng_sorted_m;
    logic          eng_start_d;
    int            eng_cnt;
    bit            eng_pend;
    logic [DW-1:0] eng_op;
    logic          eng_done_x = 1'b0;

    assign eng_done   = eng_done_m | eng_done_x;
    assign eng_sorted = eng_done_x ? {DW{1'b1}} : eng_sorted_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_done_m   <= 1'b0;
            eng_sorted_m <= '0;
            eng_start_d  <= 1'b0;
            eng_cnt      <= 0;
            eng_pend     <= 1'b0;
            eng_op       <= '0;
        end else begin
            eng_done_m  <= 1'b0;
            eng_start_d <= eng_start;
            if (eng_start && !eng_start_d) begin
                if (!eng_never) begin
                    eng_pend <= 1'b1;
                    eng_cnt  <= eng_lat - 1;
                    eng_op   <= eng_data;
                end
            end else if (eng_pend) begin
                if (eng_cnt == 1) begin
                    eng_done_m   <= 1'b1;
                    eng_sorted_m <= sort6(eng_op);
                    eng_pend     <= 1'b0;
                end
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // called in the accept cycle; counts cycles until rsp_valid, bounded
    task automatic wait_rsp(input logic [NREQ-1:0] vld_after, output int cyc, output int starts);
        cyc    = 0;
        starts = 0;
        while (cyc < 300) begin
            @(negedge clk);
            if (cyc == 0) req_valid = vld_after;
            cyc++;
            if (eng_start) starts++;
            if (rsp_valid) break;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [DW-1:0]   exp_sorted [NREQ];
    logic [NREQ-1:0] exp_gnt    [5];
    int              cyc, starts;
    bit              stable;

    initial begin
        exp_sorted[0] = pack6(1, 2, 3, 4, 5, 6);
        exp_sorted[1] = pack6(10, 20, 30, 40, 50, 60);
        exp_sorted[2] = pack6(1, 2, 3, 5, 7, 9);
        exp_sorted[3] = pack6(0, 0, 7, 7, 128, 255);
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;

        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_data  = '0;
        req_data[0*DW +: DW] = pack6(6, 5, 4, 3, 2, 1);
        req_data[1*DW +: DW] = pack6(60, 50, 40, 30, 20, 10);
        req_data[2*DW +: DW] = pack6(5, 3, 9, 1, 7, 2);
        req_data[3*DW +: DW] = pack6(255, 0, 128, 0, 7, 7);
        repeat (2) @(negedge clk);
        check("rst_ctrl", {busy, rsp_valid, eng_start, rsp_err, rsp_id}, '0);
        check("rst_req_ready", req_ready, '0);
        check("rst_jobs_done", jobs_done, '0);
        check("rst_eng_data", eng_data, '0);
        check("rst_rsp_data", rsp_data, '0);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // single job from requester 2
        req_valid = 4'b0100;
        #1 check("t1_grant", req_ready, 4'b0100);
        wait_rsp('0, cyc, starts);
        check("t1_latency", cyc, 8);
        check("t1_start_cycles", starts, 1);
        check("t1_eng_data", eng_data, pack6(5, 3, 9, 1, 7, 2));
        check("t1_id", rsp_id, 2);
        check("t1_data", rsp_data, pack6(1, 2, 3, 5, 7, 9));
        check("t1_err", rsp_err, 0);
        handshake();
        check("t1_jobs_done", jobs_done, 1);
        check("t1_idle", busy, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // round robin with all requesters active
        eng_lat   = 2;
        req_valid = '1;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("rr_grant%0d", i), req_ready, exp_gnt[i]);
            wait_rsp('1, cyc, starts);
            check($sformatf("rr_latency%0d", i), cyc, 4);
            check($sformatf("rr_id%0d", i), rsp_id, i);
            check($sformatf("rr_data%0d", i), rsp_data, exp_sorted[i]);
            rsp_ready = 1'b1;
            #1 check($sformatf("rr_no_accept_on_ready%0d", i), req_ready, '0);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        #1 check("rr_grant_wrap", req_ready, exp_gnt[4]);
        wait_rsp('1, cyc, starts);

        // backpressure: response must hold while rsp_ready stays low
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== exp_sorted[0] || rsp_id !== 2'd0 || req_ready !== '0)
                stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("hold_valid", rsp_valid, 1);
        check("hold_data", rsp_data, exp_sorted[0]);
        req_valid = '0;
        handshake();
        check("hold_jobs_done", jobs_done, 5);

        // engine never answers
        eng_never = 1'b1;
        req_valid = 4'b0010;
        #1 check("to_grant", req_ready, 4'b0010);
        wait_rsp('0, cyc, starts);
        check("to_latency", cyc, 66);
        check("to_err", rsp_err, 1);
        check("to_data", rsp_data, '0);
        check("to_id", rsp_id, 1);
        check("to_jobs_before", jobs_done, 5);
        handshake();
        check("to_jobs_after", jobs_done, 6);
        eng_never = 1'b0;

        // done in the last wait cycle beats the timeout
        eng_lat   = 64;
        req_valid = 4'b0100;
        #1 check("edge_grant", req_ready, 4'b0100);
        wait_rsp('0, cyc, starts);
        check("edge_latency", cyc, 66);
        check("edge_err", rsp_err, 0);
        check("edge_data", rsp_data, pack6(1, 2, 3, 5, 7, 9));
        handshake();
        check("edge_jobs", jobs_done, 7);

        // reset while waiting on the engine
        eng_lat   = 6;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1 check("mid_rst_busy", busy, 0);
        check("mid_rst_jobs", jobs_done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_no_rsp", {busy, rsp_valid}, 2'b00);
        req_valid = 4'b0010;
        #1 check("mid_next_grant", req_ready, 4'b0010);
        wait_rsp('0, cyc, starts);
        check("mid_next_latency", cyc, 8);
        check("mid_next_id", rsp_id, 1);
        check("mid_next_data", rsp_data, exp_sorted[1]);
        handshake();
        check("mid_next_jobs", jobs_done, 1);

        // stray eng_done in IDLE and in RESP
        eng_done_x = 1'b1;
        @(negedge clk);
        eng_done_x = 1'b0;
        check("stray_idle", {busy, rsp_valid}, 2'b00);
        req_valid = 4'b0001;
        #1 check("stray_grant", req_ready, 4'b0001);
        wait_rsp('0, cyc, starts);
        eng_done_x = 1'b1;
        @(negedge clk);
        eng_done_x = 1'b0;
        check("stray_resp_valid", rsp_valid, 1);
        check("stray_resp_data", rsp_data, exp_sorted[0]);
        handshake();
        check("stray_jobs", jobs_done, 2);
        @(negedge clk);
        check("stray_no_extra", {busy, rsp_valid}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
